pc_fetch: RTL and testbench

Instruction-fetch front end that produces the `i_pc`/`i_inst` pair consumed by the decode stage. It owns the program counter, issues word fetches to instruction memory over a request/ready and response-valid interface, and buffers returned words in a 2-entry queue. The decode side holds words using a stall input. A redirect input retargets the PC, flushes buffered words and discards in-flight responses.

---
 rtl/pc_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/pc_fetch.sv | 120 ++++++++++++
 tb/tb_pc_fetch.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pc_fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries. Empty slots are held at
// {0, NOP_INST} so the head reads as a NOP whenever the FIFO is empty.
module fetch_fifo
  import pc_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam fetch_entry_t EMPTY = '{pc: '0, inst: NOP_INST};

  fetch_entry_t     slot0_q, slot1_q, slot0_d, slot1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next-state: pop shifts slot1 forward, then push lands in the first free slot.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CNT_W'(2)) || do_pop);
    if (do_pop) begin
      slot0_d = slot1_q;
      slot1_d = EMPTY;
      count_d = count_q - CNT_W'(1);
    end
    if (do_push) begin
      if (count_d == '0) begin
        slot0_d = push_data;
      end else begin
        slot1_d = push_data;
      end
      count_d = count_d + CNT_W'(1);
    end
  end

  // Storage registers; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot0_q <= EMPTY;
      slot1_q <= EMPTY;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues word fetches with a
// two-slot credit, buffers returned words and presents them to decode.
// Optional feature macro: PC_FETCH_ALIGN_CHECK_EN (misaligned redirect
// halts fetch and raises o_misalign until reset).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_misalign
);

  logic [XLEN-1:0]  fetch_pc_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] pcq_count, outq_count;
  fetch_entry_t     pcq_head, outq_head, pcq_push_data, outq_push_data;
  logic [2:0]       credit_used;
  logic             pop, accept, rsp_ok, rsp_drop, rsp_push, pcq_pop;
  logic             halted;
  logic [XLEN-1:0]  redirect_target;

  // Credit check, request generation and response classification.
  always_comb begin
    inflight       = pcq_count + drop_q;
    pop            = o_valid & ~i_stall;
    credit_used    = 3'(inflight) + 3'(outq_count);
    o_imem_req     = ~rst & ~i_redirect & ~halted & (credit_used < (3'd2 + 3'(pop)));
    accept         = o_imem_req & i_imem_ready;
    rsp_ok         = i_imem_rvalid & (inflight != '0);
    rsp_drop       = rsp_ok & (drop_q != '0);
    pcq_pop        = rsp_ok & (drop_q == '0);
    rsp_push       = pcq_pop & ~i_redirect;
    pcq_push_data  = '{pc: fetch_pc_q, inst: NOP_INST};
    outq_push_data = pcq_head;
    outq_push_data.inst = i_imem_rdata;
  end

  // Fetch PC and stale-response drop counter; redirect wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else if (i_redirect) begin
      fetch_pc_q <= redirect_target;
      drop_q     <= inflight - CNT_W'(rsp_ok);
    end else begin
      if (accept) begin
        fetch_pc_q <= fetch_pc_q + PC_STEP;
      end
      if (rsp_drop) begin
        drop_q <= drop_q - CNT_W'(1);
      end
    end
  end

`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic halted_q;

  // Sticky halt on a misaligned redirect target, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
      halted_q <= 1'b1;
    end
  end

  assign redirect_target = i_redirect_pc;
  assign halted          = halted_q;
  assign o_misalign      = halted_q;
`else
  assign redirect_target = i_redirect_pc & ~XLEN'(3);
  assign halted          = 1'b0;
  assign o_misalign      = 1'b0;
`endif

  // PCs of requests that are still expected to return live data.
  fetch_fifo u_pcq (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (pcq_push_data),
    .pop       (pcq_pop),
    .flush     (i_redirect),
    .count     (pcq_count),
    .head      (pcq_head)
  );

  // Fetched words waiting for decode.
  fetch_fifo u_outq (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (outq_push_data),
    .pop       (pop),
    .flush     (i_redirect),
    .count     (outq_count),
    .head      (outq_head)
  );

  assign o_imem_addr = fetch_pc_q;
  assign o_valid     = (outq_count != '0);
  assign o_pc        = outq_head.pc;
  assign o_inst      = outq_head.inst;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: memory model with in-order variable latency, an
// epoch-tagged scoreboard of expected fetched words, directed sequences,
// a redirect vector table and a randomized phase.
module tb_pc_fetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

  logic        clk, rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        valid, misalign;
  logic [31:0] pc, inst;

  pc_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ready  (imem_ready),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .o_pc          (pc),
    .o_inst        (inst),
    .o_misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad, cyc, mem_lat, last_due, epoch;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          pend_ep[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] exp_fetch_pc;
  bit          halted_m, misalign_m;

  bit          o_v, o_req, o_mis, o_acc;
  logic [31:0] o_p, o_i, o_a;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] pc0;
    logic [31:0] pc1;
  } redir_vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory response, compare against the model,
  // then advance the model by the rules of the fetch unit.
  task automatic tick();
    bit          rsp, pop_m, exp_req;
    logic [31:0] rsp_addr, tgt;
    int          rsp_ep, outstanding, due;
    rsp = 1'b0; rsp_addr = '0; rsp_ep = -1;
    outstanding = pend_addr.size();
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      rsp = 1'b1;
      rsp_addr = pend_addr.pop_front();
      rsp_ep = pend_ep.pop_front();
      void'(pend_due.pop_front());
    end
    imem_rvalid = rsp;
    imem_rdata  = rsp ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
    #1;
    o_v = valid; o_p = pc; o_i = inst; o_mis = misalign;
    o_req = imem_req; o_a = imem_addr;
    o_acc = imem_req && imem_ready;
    pop_m = 1'b0;
    if (rst) begin
      chk("req_in_reset", 32'(imem_req), 32'(0));
    end else begin
      chk("valid", 32'(valid), 32'(q_pc.size() > 0));
      if (q_pc.size() > 0) chk("pc", pc, q_pc[0]);
      chk("inst", inst, (q_pc.size() > 0) ? q_inst[0] : 32'h0);
      chk("misalign", 32'(misalign), 32'(misalign_m));
      pop_m   = (q_pc.size() > 0) && !stall;
      exp_req = !redirect && !halted_m && ((outstanding + q_pc.size() - int'(pop_m)) < 2);
      chk("req", 32'(imem_req), 32'(exp_req));
      if (exp_req && imem_req) chk("addr", imem_addr, exp_fetch_pc);
    end
    if (rst) begin
      pend_addr.delete(); pend_due.delete(); pend_ep.delete();
      q_pc.delete(); q_inst.delete();
      exp_fetch_pc = TB_RESET_PC; halted_m = 1'b0; misalign_m = 1'b0;
      epoch++; last_due = cyc;
    end else begin
      if (redirect) begin
        q_pc.delete(); q_inst.delete();
        epoch++;
`ifdef PC_FETCH_ALIGN_CHECK_EN
        tgt = redirect_pc;
        if (tgt[1:0] != 2'b00) begin
          halted_m = 1'b1;
          misalign_m = 1'b1;
        end
`else
        tgt = redirect_pc & 32'hFFFF_FFFC;
`endif
        exp_fetch_pc = tgt;
      end else begin
        if (pop_m) begin
          void'(q_pc.pop_front());
          void'(q_inst.pop_front());
        end
        if (rsp && rsp_ep == epoch) begin
          q_pc.push_back(rsp_addr);
          q_inst.push_back(mem_word(rsp_addr));
        end
        if (o_acc) exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (o_acc) begin
        due = cyc + mem_lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(imem_addr);
        pend_due.push_back(due);
        pend_ep.push_back(redirect ? -1 : epoch);
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    redir_vec_t tv[$];
    int          n_acc, got;
    logic [31:0] a0, rp;
    logic [31:0] gpc[2];
    logic [31:0] ginst[2];

    tv.push_back('{target: 32'h0000_2000, lat: 3, pc0: 32'h0000_2000, pc1: 32'h0000_2004});
    tv.push_back('{target: 32'hFFFF_FFFC, lat: 1, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000});
    tv.push_back('{target: 32'h0000_4010, lat: 2, pc0: 32'h0000_4010, pc1: 32'h0000_4014});
`ifndef PC_FETCH_ALIGN_CHECK_EN
    tv.push_back('{target: 32'h0000_2002, lat: 1, pc0: 32'h0000_2000, pc1: 32'h0000_2004});
`endif

    n_cmp = 0; n_bad = 0; cyc = 0; mem_lat = 1; last_due = 0; epoch = 0;
    exp_fetch_pc = TB_RESET_PC; halted_m = 1'b0; misalign_m = 1'b0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);

    // Reset values and first request right after reset.
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 32'(o_v), 32'(0));
    chk("rst_pc", o_p, 32'h0);
    chk("rst_inst", o_i, 32'h0);
    chk("rst_misalign", 32'(o_mis), 32'(0));
    chk("first_req", 32'(o_req), 32'(1));
    chk("first_addr", o_a, TB_RESET_PC);

    // 1-cycle memory, no stall: one word per cycle from cycle 2.
    tick();
    chk("lat_cycle1_invalid", 32'(o_v), 32'(0));
    tick();
    chk("seq0_valid", 32'(o_v), 32'(1)); chk("seq0_pc", o_p, 32'h100); chk("seq0_inst", o_i, mem_word(32'h100));
    tick();
    chk("seq1_valid", 32'(o_v), 32'(1)); chk("seq1_pc", o_p, 32'h104); chk("seq1_inst", o_i, mem_word(32'h104));
    tick();
    chk("seq2_valid", 32'(o_v), 32'(1)); chk("seq2_pc", o_p, 32'h108); chk("seq2_inst", o_i, mem_word(32'h108));

    // Stall with 0x104 on head.
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick(); tick();
    stall = 1'b1; n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(o_v), 32'(1));
      chk("stall_pc", o_p, 32'h104);
      if (o_acc) n_acc++;
    end
    stall = 1'b0;
    chk("stall_accepts_le2", 32'(n_acc <= 2), 32'(1));
    tick();
    chk("release_pc", o_p, 32'h104);
    tick();
    chk("after_release_pc", o_p, 32'h108);

    // Ready held low: address frozen, output drains to NOP.
    imem_ready = 1'b0;
    tick();
    a0 = o_a;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdylow_addr_stable", o_a, a0);
      chk("rdylow_req", 32'(o_req), 32'(1));
    end
    chk("rdylow_drained_valid", 32'(o_v), 32'(0));
    chk("rdylow_inst_nop", o_i, 32'h0);
    imem_ready = 1'b1;

    // Redirect vectors: first two words after the redirect.
    foreach (tv[k]) begin
      mem_lat = tv[k].lat;
      for (int i = 0; i < 4; i++) tick();
      redirect = 1'b1; redirect_pc = tv[k].target;
      tick();
      redirect = 1'b0;
      got = 0;
      for (int i = 0; i < 40 && got < 2; i++) begin
        tick();
        if (o_v) begin
          gpc[got] = o_p; ginst[got] = o_i; got++;
        end
      end
      chk("redir_words_seen", 32'(got), 32'(2));
      if (got == 2) begin
        chk("redir_pc0", gpc[0], tv[k].pc0);
        chk("redir_pc1", gpc[1], tv[k].pc1);
        chk("redir_inst0", ginst[0], mem_word(tv[k].pc0));
        chk("redir_inst1", ginst[1], mem_word(tv[k].pc1));
      end
    end

    // Randomized traffic with stalls, ready gaps, redirects and a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      mem_lat    = $urandom_range(1, 3);
      redirect   = ($urandom_range(0, 39) == 0);
      rp = $urandom();
      if ($urandom_range(0, 4) == 0) rp = 32'hFFFF_FFF8;
`ifdef PC_FETCH_ALIGN_CHECK_EN
      rp[1:0] = 2'b00;
`endif
      redirect_pc = rp;
      rst = (i == 1500);
      tick();
    end
    rst = 1'b0; redirect = 1'b0; stall = 1'b0; imem_ready = 1'b1; mem_lat = 1;
    tick(); tick();

`ifdef PC_FETCH_ALIGN_CHECK_EN
    // Misaligned redirect halts fetch until reset.
    redirect = 1'b1; redirect_pc = 32'h0000_2002;
    tick();
    chk("mis_before", 32'(o_mis), 32'(0));
    redirect = 1'b0;
    tick();
    chk("misalign_set", 32'(o_mis), 32'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mis_no_req", 32'(o_req), 32'(0));
      chk("mis_sticky", 32'(o_mis), 32'(1));
    end
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    chk("mis_cleared", 32'(o_mis), 32'(0));
    chk("mis_req_after_rst", 32'(o_req), 32'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
